led_shift_chain: RTL and testbench
==================================

# led_shift_chain

Parametrised serial driver for a chain of 74HC595-style LED shift registers. It accepts a WIDTH-bit frame over a valid/ready handshake and shifts it out on a data/shift-clock pair, with a programmable clock divider and selectable bit order. It then pulses the storage-register latch and reports completion. It sits between the TWI/LED control registers and the board pins, and replaces the fixed 8-bit, undivided, latch-less shifter.

## Interface
Parameters:
- WIDTH, 16: frame length in bits, covering all chained registers; legal range 1..256.
- DIV, 1: half-period of sft_shcp in clk cycles; legal range 1..255.
- MSB_FIRST, 0: 0 shifts din[0] first; 1 shifts din[WIDTH-1] first.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- vld  in  1  frame valid.
- rdy  out  1  block idle and able to accept a frame.
- din  in  WIDTH  frame data; sampled only when vld && rdy.
- done  out  1  one-cycle pulse when the frame is complete.
- sft_shcp  out  1  shift clock to the chain.
- sft_ds  out  1  serial data to the chain.
- sft_stcp  out  1  storage/latch clock to the chain.

## Operation
- All outputs are registered. Reset values: rdy=1, done=0, sft_shcp=0, sft_ds=0, sft_stcp=0.
- State machine: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - rdy=1.
  - On vld, load din into the shift register, clear the bit counter and divider, and go to SHIFT_LO.
  - If vld is low, stay in IDLE.
- SHIFT_LO: sft_shcp=0 and sft_ds = current bit. Lasts DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - sft_shcp=1 and sft_ds is held. Lasts DIV cycles.
  - At the end of the phase, advance to the next bit: shift right if MSB_FIRST=0, left if MSB_FIRST=1.
  - If the bit counter is WIDTH-1, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - sft_stcp=1, sft_shcp=0, sft_ds=0. Lasts DIV cycles.
  - Then go to IDLE and pulse done for one cycle.
- Data changes only at the start of SHIFT_LO. This gives DIV cycles of setup before, and DIV cycles of hold after, each rising edge of sft_shcp.
- rdy=0 in every state other than IDLE; vld asserted while busy is ignored.
- A new frame may be accepted in the same cycle that done is high, since IDLE is re-entered that cycle.
- Counter widths:
  - Bit counter is $clog2(WIDTH) bits, minimum 1.
  - Divider is $clog2(DIV) bits, minimum 1.
  - The divider counts 0..DIV-1 and wraps to 0 at each phase change.
- rst asserted mid-frame: the next cycle is IDLE with all outputs at their reset values. No done and no latch pulse are produced, and the partial frame is discarded.

## Timing
- Cycle 0 is the clk edge on which vld && rdy is sampled.
- Bit k (k = 0..WIDTH-1):
  - sft_ds is valid from cycle 1+2k·DIV.
  - sft_shcp is high during cycles 1+(2k+1)·DIV .. 2(k+1)·DIV.
- sft_stcp is high during cycles 2·WIDTH·DIV+1 .. 2·WIDTH·DIV+DIV.
- done pulses at cycle 2·WIDTH·DIV+DIV+1, and rdy returns high in that same cycle.
- Example: WIDTH=8, DIV=1 gives latch in cycle 17 and done in cycle 18.
- Throughput with back-to-back frames: one frame per 2·WIDTH·DIV+DIV+1 cycles.

## Configuration
- LED_SHIFT_LATCH_EN defined:
  - LATCH state present.
  - sft_stcp is driven as described under Operation.
- LED_SHIFT_LATCH_EN undefined:
  - LATCH state compiled out; sft_stcp is tied to 0.
  - After the last SHIFT_HI the block goes directly to IDLE.
  - done pulses at cycle 2·WIDTH·DIV+1.

## Structure
- Package led_shift_pkg holds:
  - the state enum typedef (IDLE, SHIFT_LO, SHIFT_HI, LATCH);
  - localparam helpers for counter widths (max(1,$clog2(x))).
- Sub-module led_shift_div: the phase-tick generator. It takes start and enable, and emits a one-cycle tick at the end of every DIV-cycle phase. The FSM advances state only on this tick.

## Test plan
- WIDTH=8, DIV=1, MSB_FIRST=0, din=8'hA5: sft_ds sampled on each sft_shcp rise reads 1,0,1,0,0,1,0,1. sft_stcp is high in cycle 17, done in cycle 18, and exactly 8 sft_shcp rises occur.
- WIDTH=16, DIV=3, MSB_FIRST=1, din=16'h8001:
  - first and last sampled bits are 1, all others 0;
  - each sft_shcp high and low phase lasts 3 cycles;
  - done arrives in cycle 100.
- Back-to-back frames 8'hFF then 8'h00 with vld held high: the second frame is accepted on the done cycle with no idle gap, and 16 sft_shcp rises are counted in total.
- Pulse vld during SHIFT_HI with a different din: rdy=0, so the pulse is ignored and the shifted frame is unchanged.
- Assert rst in cycle 5 of a WIDTH=8 frame:
  - from the next cycle, all outputs are 0 and rdy=1;
  - done and sft_stcp never pulse;
  - a subsequent frame shifts correctly.
- Build without LED_SHIFT_LATCH_EN, WIDTH=8, DIV=1: sft_stcp stays 0 throughout and done arrives in cycle 17.

Source files
------------

// File: rtl/led_shift_pkg.sv
// Shared types and width helpers for the LED shift-register chain driver.
// Optional feature: define LED_SHIFT_LATCH_EN to include the storage-latch phase.
package led_shift_pkg;

`ifdef LED_SHIFT_LATCH_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } state_e;
`endif

    // Counter width for a count range of x values, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned x);
        int unsigned w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/led_shift_chain_if.sv
// Frame handshake between the LED control registers and the shift-chain driver.
// WIDTH must match the WIDTH of the led_shift_chain it connects to.
interface led_shift_chain_if #(
    parameter int unsigned WIDTH = 16
);
    logic             vld;
    logic             rdy;
    logic [WIDTH-1:0] din;
    logic             done;

    modport master (
        output vld,
        output din,
        input  rdy,
        input  done
    );

    modport slave (
        input  vld,
        input  din,
        output rdy,
        output done
    );
endinterface

// File: rtl/led_shift_div.sv
// Phase-tick generator: one-cycle tick on the last cycle of every DIV-cycle phase.
// start clears the count; the count only advances while en is high.
module led_shift_div
    import led_shift_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic tick
);

    localparam int unsigned   DW   = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Tick on the final cycle of the current phase.
    always_comb begin
        tick = en && !start && (cnt_q == LAST);
    end

    // Next count: cleared on start, wraps to zero at each phase boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_shift_chain.sv
// Serial driver for a chain of 74HC595-style LED shift registers.
// Accepts a WIDTH-bit frame, shifts it out on sft_ds/sft_shcp with each
// shcp phase lasting DIV clocks, optionally pulses sft_stcp, then pulses done.
// Optional feature: LED_SHIFT_LATCH_EN enables the LATCH phase and sft_stcp.
module led_shift_chain
    import led_shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV       = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    led_shift_chain_if.slave    bus,
    output logic                sft_shcp,
    output logic                sft_ds,
    output logic                sft_stcp
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             shcp_q, shcp_d;
    logic             ds_q, ds_d;
`ifdef LED_SHIFT_LATCH_EN
    logic             stcp_q, stcp_d;
`endif

    logic [WIDTH-1:0] sreg_adv;
    logic             first_bit;
    logic             next_bit;
    logic             accept;
    logic             tick;

    // Shift register advanced by one position toward the output end.
    always_comb begin
        sreg_adv  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        first_bit = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
        next_bit  = MSB_FIRST ? sreg_adv[WIDTH-1] : sreg_adv[0];
        accept    = (state_q == IDLE) && bus.vld;
    end

    led_shift_div #(
        .DIV(DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(accept),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Next-state and registered-output logic; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        shcp_d  = shcp_q;
        ds_d    = ds_q;
        done_d  = 1'b0;
`ifdef LED_SHIFT_LATCH_EN
        stcp_d  = stcp_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.vld) begin
                    state_d = SHIFT_LO;
                    sreg_d  = bus.din;
                    bit_d   = '0;
                    shcp_d  = 1'b0;
                    ds_d    = first_bit;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                    shcp_d  = 1'b1;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    shcp_d = 1'b0;
                    sreg_d = sreg_adv;
                    if (bit_q == LAST_BIT) begin
                        ds_d    = 1'b0;
`ifdef LED_SHIFT_LATCH_EN
                        state_d = LATCH;
                        stcp_d  = 1'b1;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 1'b1;
                        ds_d    = next_bit;
                    end
                end
            end
`ifdef LED_SHIFT_LATCH_EN
            LATCH: begin
                if (tick) begin
                    state_d = IDLE;
                    stcp_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bit_q   <= '0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            shcp_q  <= 1'b0;
            ds_q    <= 1'b0;
`ifdef LED_SHIFT_LATCH_EN
            stcp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bit_q   <= bit_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            shcp_q  <= shcp_d;
            ds_q    <= ds_d;
`ifdef LED_SHIFT_LATCH_EN
            stcp_q  <= stcp_d;
`endif
        end
    end

    assign bus.rdy  = rdy_q;
    assign bus.done = done_q;
    assign sft_shcp = shcp_q;
    assign sft_ds   = ds_q;
`ifdef LED_SHIFT_LATCH_EN
    assign sft_stcp = stcp_q;
`else
    assign sft_stcp = 1'b0;
`endif

endmodule

// File: tb/tb_led_shift_chain.sv
// Directed bench for led_shift_chain: an 8-bit LSB-first DIV=1 instance and a
// 16-bit MSB-first DIV=3 instance. Timings follow LED_SHIFT_LATCH_EN.
module tb_led_shift_chain;

`ifdef LED_SHIFT_LATCH_EN
    localparam int DONE_A   = 18;
    localparam int DONE_B   = 100;
    localparam int STCP_N_A = 1;
`else
    localparam int DONE_A   = 17;
    localparam int DONE_B   = 97;
    localparam int STCP_N_A = 0;
`endif

    logic clk;
    logic rst;
    logic shcp_a, ds_a, stcp_a;
    logic shcp_b, ds_b, stcp_b;
    int   total;
    int   bad;

    led_shift_chain_if #(.WIDTH(8))  if_a ();
    led_shift_chain_if #(.WIDTH(16)) if_b ();

    led_shift_chain #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .sft_shcp(shcp_a), .sft_ds(ds_a), .sft_stcp(stcp_a)
    );

    led_shift_chain #(.WIDTH(16), .DIV(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .sft_shcp(shcp_b), .sft_ds(ds_b), .sft_stcp(stcp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (if_a.rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_a: got %b want 1", if_a.rdy); end
        total++; if (if_a.done !== 1'b0) begin bad++; $display("FAIL reset_done_a: got %b want 0", if_a.done); end
        total++; if (shcp_a !== 1'b0) begin bad++; $display("FAIL reset_shcp_a: got %b want 0", shcp_a); end
        total++; if (ds_a !== 1'b0) begin bad++; $display("FAIL reset_ds_a: got %b want 0", ds_a); end
        total++; if (stcp_a !== 1'b0) begin bad++; $display("FAIL reset_stcp_a: got %b want 0", stcp_a); end
        total++; if (if_b.rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_b: got %b want 1", if_b.rdy); end
        total++; if ({if_b.done, shcp_b, ds_b, stcp_b} !== 4'b0000) begin
            bad++; $display("FAIL reset_outs_b: got %b want 0000", {if_b.done, shcp_b, ds_b, stcp_b});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsb_frame(input logic [7:0] d);
        logic [7:0] got = '0;
        int rises = 0, done_cyc = -1, ndone = 0, stcp_cnt = 0, stcp_first = -1;
        logic prev = 1'b0;
        if_a.vld = 1'b1;
        if_a.din = d;
        @(posedge clk);
        #1;
        if_a.vld = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 1) begin
                total++; if (if_a.rdy !== 1'b0) begin bad++; $display("FAIL lsb_busy_rdy: got %b want 0", if_a.rdy); end
            end
            if (shcp_a && !prev) begin got = {ds_a, got[7:1]}; rises++; end
            prev = shcp_a;
            if (if_a.done) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
            if (stcp_a) begin stcp_cnt++; if (stcp_first < 0) stcp_first = cyc; end
            @(posedge clk);
            #1;
        end
        total++; if (got !== d) begin bad++; $display("FAIL lsb_bits: got %h want %h", got, d); end
        total++; if (rises != 8) begin bad++; $display("FAIL lsb_rises: got %0d want 8", rises); end
        total++; if (done_cyc != DONE_A) begin bad++; $display("FAIL lsb_done_cycle: got %0d want %0d", done_cyc, DONE_A); end
        total++; if (ndone != 1) begin bad++; $display("FAIL lsb_done_count: got %0d want 1", ndone); end
        total++; if (stcp_cnt != STCP_N_A) begin bad++; $display("FAIL lsb_stcp_count: got %0d want %0d", stcp_cnt, STCP_N_A); end
`ifdef LED_SHIFT_LATCH_EN
        total++; if (stcp_first != 17) begin bad++; $display("FAIL lsb_stcp_cycle: got %0d want 17", stcp_first); end
`endif
    endtask

    task automatic test_msb_div3();
        logic [15:0] got = '0;
        int rises = 0, done_cyc = -1, run = 0, phases = 0, bad_phase = 0;
        logic prev = 1'b0;
        if_b.vld = 1'b1;
        if_b.din = 16'h8001;
        @(posedge clk);
        #1;
        if_b.vld = 1'b0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            if (shcp_b && !prev) begin got = {got[14:0], ds_b}; rises++; end
            if (shcp_b != prev) begin
                phases++;
                if (run != 3) bad_phase++;
                run = 1;
            end else begin
                run++;
            end
            prev = shcp_b;
            if (if_b.done && done_cyc < 0) done_cyc = cyc;
            @(posedge clk);
            #1;
        end
        total++; if (got !== 16'h8001) begin bad++; $display("FAIL msb_bits: got %h want 8001", got); end
        total++; if (rises != 16) begin bad++; $display("FAIL msb_rises: got %0d want 16", rises); end
        total++; if (phases != 32) begin bad++; $display("FAIL msb_phase_count: got %0d want 32", phases); end
        total++; if (bad_phase != 0) begin bad++; $display("FAIL msb_phase_len: got %0d bad phases want 0", bad_phase); end
        total++; if (done_cyc != DONE_B) begin bad++; $display("FAIL msb_done_cycle: got %0d want %0d", done_cyc, DONE_B); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got = '0;
        int rises = 0, ndone = 0, d1 = -1, d2 = -1;
        logic prev = 1'b0;
        if_a.vld = 1'b1;
        if_a.din = 8'hFF;
        @(posedge clk);
        #1;
        if_a.din = 8'h00;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (d1 > 0 && cyc == d1 + 1) begin
                total++; if ({if_a.rdy, shcp_a} !== 2'b00) begin
                    bad++; $display("FAIL b2b_no_gap: got rdy,shcp=%b want 00", {if_a.rdy, shcp_a});
                end
                if_a.vld = 1'b0;
            end
            if (shcp_a && !prev) begin got = {ds_a, got[15:1]}; rises++; end
            prev = shcp_a;
            if (if_a.done) begin
                ndone++;
                if (d1 < 0) d1 = cyc; else if (d2 < 0) d2 = cyc;
            end
            @(posedge clk);
            #1;
        end
        if_a.vld = 1'b0;
        total++; if (rises != 16) begin bad++; $display("FAIL b2b_rises: got %0d want 16", rises); end
        total++; if (got !== 16'h00FF) begin bad++; $display("FAIL b2b_bits: got %h want 00ff", got); end
        total++; if (ndone != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        total++; if (d1 != DONE_A) begin bad++; $display("FAIL b2b_first_done: got %0d want %0d", d1, DONE_A); end
        total++; if (d2 - d1 != DONE_A) begin bad++; $display("FAIL b2b_period: got %0d want %0d", d2 - d1, DONE_A); end
    endtask

    task automatic test_vld_while_busy();
        logic [7:0] got = '0;
        int rises = 0, ndone = 0;
        logic prev = 1'b0;
        if_a.vld = 1'b1;
        if_a.din = 8'h3C;
        @(posedge clk);
        #1;
        if_a.vld = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 2) begin
                total++; if ({shcp_a, if_a.rdy} !== 2'b10) begin
                    bad++; $display("FAIL busy_hi_rdy: got shcp,rdy=%b want 10", {shcp_a, if_a.rdy});
                end
                if_a.vld = 1'b1;
                if_a.din = 8'hC3;
            end
            if (cyc == 3) if_a.vld = 1'b0;
            if (shcp_a && !prev) begin got = {ds_a, got[7:1]}; rises++; end
            prev = shcp_a;
            if (if_a.done) ndone++;
            @(posedge clk);
            #1;
        end
        total++; if (got !== 8'h3C) begin bad++; $display("FAIL busy_bits: got %h want 3c", got); end
        total++; if (rises != 8) begin bad++; $display("FAIL busy_rises: got %0d want 8", rises); end
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_mid_reset();
        int rises = 0, ndone = 0, nstcp = 0;
        logic prev = 1'b0;
        if_a.vld = 1'b1;
        if_a.din = 8'hA5;
        @(posedge clk);
        #1;
        if_a.vld = 1'b0;
        for (int cyc = 1; cyc < 5; cyc++) begin
            @(posedge clk);
            #1;
        end
        total++; if (ds_a !== 1'b1) begin bad++; $display("FAIL mid_pre_ds: got %b want 1", ds_a); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (if_a.rdy !== 1'b1) begin bad++; $display("FAIL mid_rst_rdy: got %b want 1", if_a.rdy); end
        total++; if ({if_a.done, shcp_a, ds_a, stcp_a} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_outs: got %b want 0000", {if_a.done, shcp_a, ds_a, stcp_a});
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (shcp_a && !prev) rises++;
            prev = shcp_a;
            if (if_a.done) ndone++;
            if (stcp_a) nstcp++;
            @(posedge clk);
            #1;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", ndone); end
        total++; if (nstcp != 0) begin bad++; $display("FAIL mid_no_stcp: got %0d want 0", nstcp); end
        total++; if (rises != 0) begin bad++; $display("FAIL mid_no_shift: got %0d want 0", rises); end
        test_lsb_frame(8'h5A);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        if_a.vld = 1'b0;
        if_a.din = '0;
        if_b.vld = 1'b0;
        if_b.din = '0;
        test_reset();
        test_lsb_frame(8'hA5);
        test_msb_div3();
        test_back_to_back();
        test_vld_while_busy();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
